// File: rtl/register_file_1r_2w_asymm.sv
// Register file with one narrow write port, one wide wrapping write port and one registered read port.
// Optional macro RF_WRITE_BYPASS_EN forwards same-cycle write data to the read port.
module register_file_1r_2w_asymm_word #(
  parameter int DATA_WIDTH = 32,
  parameter int NUM_BYTE   = DATA_WIDTH/8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NUM_BYTE-1:0]   be_a,
  input  logic [DATA_WIDTH-1:0] data_a,
  input  logic [NUM_BYTE-1:0]   be_b,
  input  logic [DATA_WIDTH-1:0] data_b,
  output logic [DATA_WIDTH-1:0] q,
  output logic [DATA_WIDTH-1:0] nxt
);
  // Port a takes priority per byte; untouched bytes hold.
  always_comb begin
    nxt = q;
    for (int k = 0; k < NUM_BYTE; k++) begin
      if (be_a[k])      nxt[k*8 +: 8] = data_a[k*8 +: 8];
      else if (be_b[k]) nxt[k*8 +: 8] = data_b[k*8 +: 8];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) q <= '0;
    else        q <= nxt;
  end
endmodule

module register_file_1r_2w_asymm #(
  parameter int ADDR_WIDTH   = 5,
  parameter int DATA_WIDTH   = 32,
  parameter int NUM_BYTE     = DATA_WIDTH/8,
  parameter int ASYMM_FACTOR = 3
) (
  input  logic                                        clk,
  input  logic                                        rst_n,
  input  logic                                        ReadEnable,
  input  logic [ADDR_WIDTH-1:0]                       ReadAddr,
  output logic [DATA_WIDTH-1:0]                       ReadData,
  input  logic                                        WriteEnable_a,
  input  logic [ADDR_WIDTH-1:0]                       WriteAddr_a,
  input  logic [NUM_BYTE-1:0][7:0]                    WriteData_a,
  input  logic [NUM_BYTE-1:0]                         WriteBE_a,
  input  logic                                        WriteEnable_b,
  input  logic [ADDR_WIDTH-1:0]                       WriteAddr_b,
  input  logic [ASYMM_FACTOR-1:0][NUM_BYTE-1:0][7:0]  WriteData_b,
  input  logic [ASYMM_FACTOR-1:0][NUM_BYTE-1:0]       WriteBE_b
);
  localparam int NUM_WORDS = 2**ADDR_WIDTH;

  logic [NUM_WORDS-1:0][DATA_WIDTH-1:0] mem, nxt;

  for (genvar w = 0; w < NUM_WORDS; w++) begin : g_word
    localparam logic [ADDR_WIDTH-1:0] WA = ADDR_WIDTH'(w);
    logic [ADDR_WIDTH-1:0] off;
    logic [NUM_BYTE-1:0]   be_a, be_b;
    logic [DATA_WIDTH-1:0] data_b;

    assign be_a = (WriteEnable_a && WriteAddr_a == WA) ? WriteBE_a : '0;
    // Distance from the wide base, modulo the address space; at most one beat word lands here.
    assign off  = WA - WriteAddr_b;

    always_comb begin
      be_b   = '0;
      data_b = '0;
      if (WriteEnable_b) begin
        for (int j = 0; j < ASYMM_FACTOR; j++) begin
          if (off == ADDR_WIDTH'(j)) begin
            be_b   = WriteBE_b[j];
            data_b = WriteData_b[j];
          end
        end
      end
    end

    register_file_1r_2w_asymm_word #(
      .DATA_WIDTH (DATA_WIDTH),
      .NUM_BYTE   (NUM_BYTE)
    ) u_word (
      .clk    (clk),
      .rst_n  (rst_n),
      .be_a   (be_a),
      .data_a (WriteData_a),
      .be_b   (be_b),
      .data_b (data_b),
      .q      (mem[w]),
      .nxt    (nxt[w])
    );
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ReadData <= '0;
    else if (ReadEnable) begin
`ifdef RF_WRITE_BYPASS_EN
      ReadData <= nxt[ReadAddr];
`else
      ReadData <= mem[ReadAddr];
`endif
    end
  end
endmodule

// File: doc/register_file_1r_2w_asymm.md
Name: register_file_1r_2w_asymm

Overview:
- Latch/flop register file that is the write-side counterpart of the asymmetric-read register file.
- A narrow write port (a) writes one word.
- A wide write port (b) writes ASYMM_FACTOR consecutive words in one cycle, with circular wrap over the address space.
- One registered narrow read port.
- Used by accelerator load units that fill local operand storage with wide beats while a controller patches single words.

Parameters:
- ADDR_WIDTH, 5: word address width; NUM_WORDS = 2**ADDR_WIDTH.
- DATA_WIDTH, 32: word width in bits; must be a multiple of 8.
- NUM_BYTE, DATA_WIDTH/8: byte lanes per word.
- ASYMM_FACTOR, 3: words per port-b write; legal range 1..NUM_WORDS.

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- ReadEnable  in  1  read strobe
- ReadAddr  in  ADDR_WIDTH  read word address
- ReadData  out  DATA_WIDTH  registered read data
- WriteEnable_a  in  1  narrow write strobe
- WriteAddr_a  in  ADDR_WIDTH  narrow write address
- WriteData_a  in  NUM_BYTE x 8  narrow write data
- WriteBE_a  in  NUM_BYTE  narrow byte enables
- WriteEnable_b  in  1  wide write strobe
- WriteAddr_b  in  ADDR_WIDTH  wide write base address
- WriteData_b  in  ASYMM_FACTOR x NUM_BYTE x 8  wide write data; word j occupies bits [j*DATA_WIDTH +: DATA_WIDTH]
- WriteBE_b  in  ASYMM_FACTOR x NUM_BYTE  wide byte enables; word j uses [j*NUM_BYTE +: NUM_BYTE]

Behaviour:
- Reset (rst_n low, asynchronous):
  - all NUM_WORDS storage words clear to 0.
  - ReadData clears to 0.
  - Takes effect mid-operation; any write in that cycle is lost.
- Port a write: on a clk rising edge with WriteEnable_a=1, byte k of word WriteAddr_a takes WriteData_a[k] if WriteBE_a[k]=1. Other bytes hold.
- Port b write:
  - On a clk rising edge with WriteEnable_b=1, for j=0..ASYMM_FACTOR-1, word (WriteAddr_b + j) mod NUM_WORDS takes byte k of data word j if WriteBE_b[j*NUM_BYTE+k]=1.
  - Wrap example, NUM_WORDS=32, base 31, factor 3: words 31, 0, 1.
  - ASYMM_FACTOR = NUM_WORDS writes every word exactly once; no word is written twice.
- Collision: when both ports enable the same byte of the same word in one cycle, port a wins per byte. Non-colliding bytes from both ports are all written.
- Write latency: the write is visible in storage after 1 edge.
- Read:
  - ReadData is updated on a clk edge with ReadEnable=1 to word ReadAddr, using storage contents before that edge's writes (read-old-data).
  - Read latency is 1 cycle.
  - With ReadEnable=0, ReadData holds its value.
- No handshake; all ports accept every cycle. No backpressure.
- Write-enable decode is one-hot per word per byte; unaddressed words hold.

Optional Feature:
- Macro: RF_WRITE_BYPASS_EN.
- When defined: on a read whose ReadAddr matches a word written in the same cycle, ReadData takes the merged new value. Merge is per byte, applying the same port-a-over-port-b priority; unwritten bytes come from storage.
- When undefined: read-old-data as above. Storage contents are identical in both cases.

Test Plan:
- Reset with all storage preloaded, release rst_n, then read addresses 0..31 -> every ReadData = 0x00000000.
- Port-b write, base 4, data {0xCCCCCCCC,0xBBBBBBBB,0xAAAAAAAA}, BE all 1, then read 4,5,6,7 -> 0xAAAAAAAA, 0xBBBBBBBB, 0xCCCCCCCC, 0x00000000.
- Port-b write, base 31, same data -> word31=0xAAAAAAAA, word0=0xBBBBBBBB, word1=0xCCCCCCCC; word2 unchanged.
- Same cycle: port-a write addr 0, 0x11223344, BE=0b0011; port-b write base 31 as above -> word0 = 0xBBBB3344.
- Read addr 5 in the same cycle as a port-b write covering 5 with 0x12345678 (old value 0xBBBBBBBB) -> ReadData = 0xBBBBBBBB without RF_WRITE_BYPASS_EN, 0x12345678 with it; next read gives 0x12345678 in both builds.
- Read with ReadEnable=0 for 3 cycles while writing the addressed word -> ReadData holds the previous value.
